// File: rtl/mcycle_sequencer_pkg.sv
// Shared definitions for the M-cycle / T-state sequencer.
//   - seq_state_e        : sequencer FSM encoding (RUN, HALT, ERROR)
//   - STEP_ONEHOT_FIRST  : T1 pattern of the one-hot step vector
//   - STEP_ONEHOT_LAST   : T4 pattern (M-cycle boundary T-state)
//   - COUNT_ONEHOT_FIRST : M1 pattern of the one-hot M-cycle count
//   - CB_PREFIX_OPCODE   : opcode that opens the CB instruction page
package mcycle_sequencer_pkg;

  localparam int SEQ_STEPS   = 4;
  localparam int SEQ_MCYCLES = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_ERROR = 2'b10
  } seq_state_e;

  localparam logic [SEQ_STEPS-1:0]   STEP_ONEHOT_FIRST  = 4'b0001;
  localparam logic [SEQ_STEPS-1:0]   STEP_ONEHOT_LAST   = 4'b1000;
  localparam logic [SEQ_MCYCLES-1:0] COUNT_ONEHOT_FIRST = 8'h01;
  localparam logic [7:0]             CB_PREFIX_OPCODE   = 8'hCB;

endpackage

// File: rtl/mcycle_sequencer_if.sv
// Bus between the sequencer and the microcode / memory side.
//   i_Wait      : wait-state, freezes the sequencer for one clock
//   i_IR_Fetch  : OR of all microcode fetch requests (level per M-cycle)
//   i_Halt_Req  : HALT microcode request (level)
//   i_Wake      : pending-interrupt wake (level)
//   i_Data_Bus  : memory read data, opcode source
//   o_*         : step/count one-hots, IR, CB page flag, exec enable,
//                 halt and sticky sequence-error status
// Modports: master drives the i_* side, slave is the sequencer.
interface mcycle_sequencer_if #(
  parameter int STEPS   = 4,
  parameter int MCYCLES = 8
);
  logic               i_Wait;
  logic               i_IR_Fetch;
  logic               i_Halt_Req;
  logic               i_Wake;
  logic [7:0]         i_Data_Bus;
  logic [STEPS-1:0]   o_Cycle_Step;
  logic [MCYCLES-1:0] o_Cycle_Count;
  logic [7:0]         o_IR;
  logic               o_CB_Prefix;
  logic               o_Exec_En;
  logic               o_Halted;
  logic               o_Seq_Error;

  modport master (
    output i_Wait, i_IR_Fetch, i_Halt_Req, i_Wake, i_Data_Bus,
    input  o_Cycle_Step, o_Cycle_Count, o_IR, o_CB_Prefix,
           o_Exec_En, o_Halted, o_Seq_Error
  );

  modport slave (
    input  i_Wait, i_IR_Fetch, i_Halt_Req, i_Wake, i_Data_Bus,
    output o_Cycle_Step, o_Cycle_Count, o_IR, o_CB_Prefix,
           o_Exec_En, o_Halted, o_Seq_Error
  );
endinterface

// File: rtl/mcycle_sequencer_onehot_rotator.sv
// One-hot shift register with enable and synchronous load to FIRST.
//   clk, rst_n : clock, asynchronous active-low reset (to FIRST)
//   en         : shift one position towards the MSB
//   load       : return to FIRST; wins over en
//   value      : current one-hot vector
// WRAP=1 rotates the MSB back into bit 0; WRAP=0 shifts a zero in, so
// the vector empties if shifted past the top.
module onehot_rotator #(
  parameter int               WIDTH = 4,
  parameter bit               WRAP  = 1'b1,
  parameter logic [WIDTH-1:0] FIRST = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic [WIDTH-1:0] shifted;

  assign shifted[0] = WRAP ? value_q[WIDTH-1] : 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_shift
      assign shifted[gi] = value_q[gi-1];
    end
  endgenerate

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = FIRST;
    end else if (en) begin
      value_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= FIRST;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/mcycle_sequencer.sv
// Timing and instruction-register engine for the opcode microcode.
//   i_Clk     : clock, one T-state per clock without wait
//   i_Reset_n : asynchronous active-low reset
//   bus       : sequencer side of mcycle_sequencer_if (see that file)
// The step vector rotates every non-waited clock in every state. All
// other state changes only at an M-cycle boundary (last T-state).
module mcycle_sequencer
  import mcycle_sequencer_pkg::*;
#(
  parameter int         STEPS        = SEQ_STEPS,
  parameter int         MCYCLES      = SEQ_MCYCLES,
  parameter logic [7:0] RESET_OPCODE = 8'h00
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset_n,
  mcycle_sequencer_if.slave    bus
);

  seq_state_e         state_q, state_d;
  logic [7:0]         ir_q, ir_d;
  logic               cb_q, cb_d;
  logic               exec_en_q, exec_en_d;
  logic               err_q, err_d;
  logic [STEPS-1:0]   step_q;
  logic [MCYCLES-1:0] count_q;
  logic               enable;
  logic               boundary;
  logic               count_adv;
  logic               count_load;

  assign enable   = !bus.i_Wait;
  assign boundary = enable && step_q[STEPS-1];

  onehot_rotator #(
    .WIDTH (STEPS),
    .WRAP  (1'b1),
    .FIRST (STEPS'(STEP_ONEHOT_FIRST))
  ) u_step (
    .clk   (i_Clk),
    .rst_n (i_Reset_n),
    .en    (enable),
    .load  (1'b0),
    .value (step_q)
  );

  onehot_rotator #(
    .WIDTH (MCYCLES),
    .WRAP  (1'b0),
    .FIRST (MCYCLES'(COUNT_ONEHOT_FIRST))
  ) u_count (
    .clk   (i_Clk),
    .rst_n (i_Reset_n),
    .en    (count_adv),
    .load  (count_load),
    .value (count_q)
  );

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    cb_d       = cb_q;
    exec_en_d  = exec_en_q;
    err_d      = err_q;
    count_adv  = 1'b0;
    count_load = 1'b0;
    if (boundary) begin
      unique case (state_q)
        ST_RUN: begin
          // Halt beats a simultaneous fetch so IR keeps the HALT opcode.
          if (bus.i_Halt_Req) begin
            state_d   = ST_HALT;
            exec_en_d = 1'b0;
          end else if (bus.i_IR_Fetch) begin
            ir_d       = bus.i_Data_Bus;
            count_load = 1'b1;
            // A CB fetched as the operand of a CB prefix is a plain opcode.
            cb_d       = (bus.i_Data_Bus == CB_PREFIX_OPCODE) && !cb_q;
          end else if (count_q[MCYCLES-1]) begin
            state_d   = ST_ERROR;
            exec_en_d = 1'b0;
            err_d     = 1'b1;
          end else begin
            count_adv = 1'b1;
          end
        end
        ST_HALT: begin
          // Advance into the HALT microcode's fetch M-cycle on wake.
          if (bus.i_Wake) begin
            state_d   = ST_RUN;
            exec_en_d = 1'b1;
            count_adv = 1'b1;
          end
        end
        default: begin
          // ERROR: frozen until reset.
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= ST_RUN;
      ir_q      <= RESET_OPCODE;
      cb_q      <= 1'b0;
      exec_en_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cb_q      <= cb_d;
      exec_en_q <= exec_en_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_Cycle_Step  = step_q;
  assign bus.o_Cycle_Count = count_q;
  assign bus.o_IR          = ir_q;
  assign bus.o_CB_Prefix   = cb_q;
  assign bus.o_Exec_En     = exec_en_q;
  assign bus.o_Halted      = (state_q == ST_HALT);
  assign bus.o_Seq_Error   = err_q;

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Bench for mcycle_sequencer: a directed vector table covering the
// fetch/LD-imm/wait/CB/halt/error scenarios, an async reset taken in the
// middle of a clock, then randomized stimulus against an index-based model.
module tb_mcycle_sequencer;
  import mcycle_sequencer_pkg::*;

  logic clk;
  logic rst_n;

  mcycle_sequencer_if #(.STEPS(4), .MCYCLES(8)) bus ();

  mcycle_sequencer #(
    .STEPS        (4),
    .MCYCLES      (8),
    .RESET_OPCODE (8'h00)
  ) dut (
    .i_Clk     (clk),
    .i_Reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         w, f, h, k;
    logic [7:0] d;
    logic [3:0] e_step;
    logic [7:0] e_cnt;
    logic [7:0] e_ir;
    bit         e_cb, e_halt, e_exec, e_err;
    int         tag;
  } vec_t;

  vec_t vq[$];
  int   cur_tag;
  int   n_pass;
  int   n_total;

  localparam logic [23:0] RESET_OUT = {4'b0001, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

  function automatic void add(bit w, bit f, bit h, bit k, logic [7:0] d,
                              logic [3:0] s, logic [7:0] c, logic [7:0] ir,
                              bit cb, bit hl, bit ex, bit er);
    vec_t v;
    v.w = w; v.f = f; v.h = h; v.k = k; v.d = d;
    v.e_step = s; v.e_cnt = c; v.e_ir = ir;
    v.e_cb = cb; v.e_halt = hl; v.e_exec = ex; v.e_err = er;
    v.tag = cur_tag;
    vq.push_back(v);
  endfunction

  function automatic logic [23:0] observe();
    return {bus.o_Cycle_Step, bus.o_Cycle_Count, bus.o_IR, bus.o_CB_Prefix,
            bus.o_Halted, bus.o_Exec_En, bus.o_Seq_Error};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s step=%b cnt=%b ir=%h cb/halt/exec/err=%b",
               name, act[23:20], act[19:12], act[11:4], act[3:0]);
    end else begin
      $display("FAIL %s got step=%b cnt=%b ir=%h cb/halt/exec/err=%b required step=%b cnt=%b ir=%h cb/halt/exec/err=%b",
               name, act[23:20], act[19:12], act[11:4], act[3:0],
               exp[23:20], exp[19:12], exp[11:4], exp[3:0]);
    end
  endtask

  // Called at a negedge; drives one clock and returns outputs #1 after
  // the posedge, ending at the following negedge.
  task automatic tick(input bit w, input bit f, input bit h, input bit k,
                      input logic [7:0] d, output logic [23:0] obs);
    bus.i_Wait     = w;
    bus.i_IR_Fetch = f;
    bus.i_Halt_Req = h;
    bus.i_Wake     = k;
    bus.i_Data_Bus = d;
    @(posedge clk);
    #1;
    obs = observe();
    @(negedge clk);
  endtask

  // Async reset asserted mid-cycle, held across a posedge, released at a negedge.
  task automatic do_reset(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    check({name, "_assert"}, observe(), RESET_OUT);
    @(posedge clk);
    #1;
    check({name, "_hold"}, observe(), RESET_OUT);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: T-state index, M-cycle index, IR, CB flag, mode.
  int         mt, mm, mmode;  // mmode: 0 run, 1 halt, 2 error
  logic [7:0] mir;
  bit         mcb;

  function automatic void model_reset();
    mt = 0; mm = 0; mmode = 0; mir = 8'h00; mcb = 1'b0;
  endfunction

  function automatic void model_clock(bit w, bit f, bit h, bit k, logic [7:0] d);
    bit last;
    if (w) return;
    last = (mt == 3);
    mt = (mt + 1) % 4;
    if (!last) return;
    if (mmode == 0) begin
      if (h) mmode = 1;
      else if (f) begin
        mir = d;
        mcb = (d == 8'hCB) && !mcb;
        mm  = 0;
      end else if (mm == 7) mmode = 2;
      else if (mm < 8) mm = mm + 1;
    end else if (mmode == 1) begin
      if (k) begin
        mmode = 0;
        if (mm < 8) mm = mm + 1;
      end
    end
  endfunction

  function automatic logic [23:0] model_out();
    logic [3:0] s;
    logic [7:0] c;
    s = 4'b0001 << mt;
    c = (mm >= 8) ? 8'h00 : (8'h01 << mm);
    return {s, c, mir, mcb, (mmode == 1), (mmode == 0), (mmode == 2)};
  endfunction

  localparam logic [3:0] S1 = 4'b0001;
  localparam logic [3:0] S2 = 4'b0010;
  localparam logic [3:0] S3 = 4'b0100;
  localparam logic [3:0] S4 = STEP_ONEHOT_LAST;

  initial begin
    logic [23:0] obs;
    logic [7:0]  c;
    bit          e;
    int          starve;
    int          err_clocks;

    n_pass = 0;
    n_total = 0;

    // T1: fetch 3E at the first boundary.
    cur_tag = 1;
    add(0,1,0,0,8'h00, S2,8'h01,8'h00, 0,0,1,0);
    add(0,1,0,0,8'h00, S3,8'h01,8'h00, 0,0,1,0);
    add(0,1,0,0,8'h00, S4,8'h01,8'h00, 0,0,1,0);
    add(0,1,0,0,8'h3E, S1,8'h01,8'h3E, 0,0,1,0);
    // T2: LD immediate, M1 no fetch, M2 fetch -> new opcode at clock 8.
    cur_tag = 2;
    add(0,0,0,0,8'h11, S2,8'h01,8'h3E, 0,0,1,0);
    add(0,0,0,0,8'h11, S3,8'h01,8'h3E, 0,0,1,0);
    add(0,0,0,0,8'h11, S4,8'h01,8'h3E, 0,0,1,0);
    add(0,0,0,0,8'h11, S1,8'h02,8'h3E, 0,0,1,0);
    add(0,1,0,0,8'h00, S2,8'h02,8'h3E, 0,0,1,0);
    add(0,1,0,0,8'h00, S3,8'h02,8'h3E, 0,0,1,0);
    add(0,1,0,0,8'h00, S4,8'h02,8'h3E, 0,0,1,0);
    add(0,1,0,0,8'h42, S1,8'h01,8'h42, 0,0,1,0);
    // T3: three wait clocks at step 0100; boundary lands at clock 7.
    cur_tag = 3;
    add(0,0,0,0,8'h00, S2,8'h01,8'h42, 0,0,1,0);
    add(0,0,0,0,8'h00, S3,8'h01,8'h42, 0,0,1,0);
    add(1,1,1,0,8'hCB, S3,8'h01,8'h42, 0,0,1,0);
    add(1,1,1,0,8'hCB, S3,8'h01,8'h42, 0,0,1,0);
    add(1,1,1,0,8'hCB, S3,8'h01,8'h42, 0,0,1,0);
    add(0,1,0,0,8'h00, S4,8'h01,8'h42, 0,0,1,0);
    add(0,1,0,0,8'hCB, S1,8'h01,8'hCB, 1,0,1,0);
    // T4: CB then CB (wait on the boundary clock first), then 00.
    cur_tag = 4;
    add(0,1,0,0,8'h00, S2,8'h01,8'hCB, 1,0,1,0);
    add(0,1,0,0,8'h00, S3,8'h01,8'hCB, 1,0,1,0);
    add(0,1,0,0,8'h00, S4,8'h01,8'hCB, 1,0,1,0);
    add(1,1,0,0,8'h99, S4,8'h01,8'hCB, 1,0,1,0);
    add(0,1,0,0,8'hCB, S1,8'h01,8'hCB, 0,0,1,0);
    add(0,1,0,0,8'h00, S2,8'h01,8'hCB, 0,0,1,0);
    add(0,1,0,0,8'h00, S3,8'h01,8'hCB, 0,0,1,0);
    add(0,1,0,0,8'h00, S4,8'h01,8'hCB, 0,0,1,0);
    add(0,1,0,0,8'h00, S1,8'h01,8'h00, 0,0,1,0);
    // T5: halt wins over fetch; wake raised at step 0010, effective at boundary.
    cur_tag = 5;
    add(0,1,1,0,8'h55, S2,8'h01,8'h00, 0,0,1,0);
    add(0,1,1,0,8'h55, S3,8'h01,8'h00, 0,0,1,0);
    add(0,1,1,0,8'h55, S4,8'h01,8'h00, 0,0,1,0);
    add(0,1,1,0,8'h55, S1,8'h01,8'h00, 0,1,0,0);
    add(0,0,0,0,8'h00, S2,8'h01,8'h00, 0,1,0,0);
    add(0,0,0,1,8'h00, S3,8'h01,8'h00, 0,1,0,0);
    add(0,0,0,1,8'h00, S4,8'h01,8'h00, 0,1,0,0);
    add(0,0,0,1,8'h00, S1,8'h02,8'h00, 0,0,1,0);
    // T6: fetch, then eight M-cycles without fetch -> error at 8th boundary.
    cur_tag = 6;
    add(0,1,0,0,8'h00, S2,8'h02,8'h00, 0,0,1,0);
    add(0,1,0,0,8'h00, S3,8'h02,8'h00, 0,0,1,0);
    add(0,1,0,0,8'h00, S4,8'h02,8'h00, 0,0,1,0);
    add(0,1,0,0,8'h00, S1,8'h01,8'h00, 0,0,1,0);
    c = 8'h01;
    e = 1'b0;
    for (int m = 0; m < 8; m++) begin
      for (int t = 0; t < 4; t++) begin
        if (t == 3) begin
          if (c == 8'h80) e = 1'b1;
          else c = c << 1;
        end
        add(0,0,0,0,8'h00, 4'(4'b0001 << ((t + 1) % 4)), c, 8'h00, 0,0,!e,e);
      end
    end
    // Error is sticky; fetches are ignored, step still rotates.
    for (int t = 0; t < 4; t++)
      add(0,1,0,1,8'h77, 4'(4'b0001 << ((t + 1) % 4)), 8'h80, 8'h00, 0,0,0,1);

    // Power-on reset.
    rst_n = 1'b0;
    bus.i_Wait = 0; bus.i_IR_Fetch = 0; bus.i_Halt_Req = 0;
    bus.i_Wake = 0; bus.i_Data_Bus = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", observe(), RESET_OUT);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      tick(vq[i].w, vq[i].f, vq[i].h, vq[i].k, vq[i].d, obs);
      check($sformatf("vec%0d_T%0d", i, vq[i].tag), obs,
            {vq[i].e_step, vq[i].e_cnt, vq[i].e_ir, vq[i].e_cb,
             vq[i].e_halt, vq[i].e_exec, vq[i].e_err});
    end

    // Leave error via async reset taken in the middle of a cycle.
    do_reset("error_clear");

    // Randomized phase against the reference model.
    model_reset();
    starve = 0;
    err_clocks = 0;
    for (int i = 0; i < 600; i++) begin
      bit w, f, h, k;
      logic [7:0] d;
      if (i % 80 == 0) starve = ($urandom_range(0, 2) == 0);
      w = ($urandom_range(0, 7) == 0);
      f = starve ? 1'b0 : ($urandom_range(0, 2) != 0);
      h = starve ? 1'b0 : ($urandom_range(0, 15) == 0);
      k = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom);
      model_clock(w, f, h, k, d);
      tick(w, f, h, k, d, obs);
      check($sformatf("rand%0d", i), obs, model_out());
      if (mmode == 2) err_clocks++;
      if (err_clocks >= 6) begin
        do_reset($sformatf("rand_reset%0d", i));
        model_reset();
        err_clocks = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mcycle_sequencer.md
Name: mcycle_sequencer

Overview:
- Timing and instruction-register engine that drives every opcode microcode block.
- Produces the one-hot T-state step (i_Cycle_Step) and the one-hot M-cycle count (i_Cycle_Count) that each microcode block decodes.
- Consumes the OR-reduced IR fetch request from those blocks and latches the next opcode into IR at the end of the fetch M-cycle.
- Handles CB-prefix tracking, HALT freeze, bus wait-states and a runaway-sequence trap.

Parameters:
- STEPS, 4, T-states per M-cycle; width of o_Cycle_Step.
- MCYCLES, 8, maximum M-cycles per instruction; width of o_Cycle_Count.
- RESET_OPCODE, 8'h00, IR value loaded at reset (NOP).

Ports:
- i_Clk  in  1  system clock; one T-state per enabled clock.
- i_Reset_n  in  1  asynchronous active-low reset.
- i_Wait  in  1  bus/DMA wait; freezes all sequencer state for that clock.
- i_IR_Fetch  in  1  OR of all microcode o_IR_Fetch; level, valid for the whole M-cycle.
- i_Halt_Req  in  1  from HALT microcode; level.
- i_Wake  in  1  pending-interrupt wake request; level.
- i_Data_Bus  in  8  memory read data; opcode source.
- o_Cycle_Step  out  STEPS  one-hot T-state.
- o_Cycle_Count  out  MCYCLES  one-hot M-cycle index within the instruction.
- o_IR  out  8  current opcode.
- o_CB_Prefix  out  1  current o_IR is a CB-page opcode.
- o_Exec_En  out  1  gates microcode i_Active; low in HALT and ERROR.
- o_Halted  out  1  FSM in HALT.
- o_Seq_Error  out  1  sticky; count overran without a fetch.

Behaviour:
- Reset (async, i_Reset_n=0):
  - o_Cycle_Step=0001, o_Cycle_Count=0000_0001, o_IR=RESET_OPCODE, o_CB_Prefix=0.
  - FSM=RUN, o_Exec_En=1, o_Halted=0, o_Seq_Error=0.
  - The first instruction executed is the NOP, whose M1 fetch loads the opcode at PC=0.
- Wait has priority:
  - If i_Wait=1 on a clock edge, no register changes.
  - Outputs hold; wait can stretch any T-state indefinitely.
- Step: rotate left each enabled clock (0001→0010→0100→1000→0001), in every FSM state.
- M-cycle boundary is an enabled clock while o_Cycle_Step[STEPS-1]=1. All other registers update only at a boundary.
- FSM RUN, at a boundary, evaluated in this order:
  - i_Halt_Req=1: → HALT. Count and IR held; the halt request overrides any simultaneous fetch.
  - i_IR_Fetch=1: IR ← i_Data_Bus, count ← 0000_0001, o_CB_Prefix ← (i_Data_Bus==8'hCB) & !o_CB_Prefix. A CB opcode fetched as a CB-page operand is not a prefix.
  - else if o_Cycle_Count[MCYCLES-1]=1: → ERROR, o_Seq_Error ← 1, count held.
  - else: count shifts left one.
- FSM HALT:
  - o_Exec_En=0, o_Halted=1; step keeps rotating.
  - At a boundary with i_Wake=1: → RUN with count advanced one position, so the HALT microcode's fetch M-cycle runs next.
  - i_Wake is ignored mid-M-cycle. Wake takes effect at the first boundary where it is sampled high.
- FSM ERROR: o_Exec_En=0; all state frozen except step; exit only by reset.
- o_Exec_En is a registered output updated with the FSM (no combinational path from inputs).
- Latency: the opcode on i_Data_Bus at the fetch boundary is visible on o_IR on the next clock, coincident with step=0001 and count=0000_0001.

Decomposition:
- Shared CPU package holds:
  - FSM state encoding (RUN, HALT, ERROR);
  - STEP_ONEHOT_FIRST/LAST and COUNT_ONEHOT_FIRST constants;
  - the CB_PREFIX_OPCODE=8'hCB constant.
- One sub-module: onehot_rotator (parameterised width, enable, wrap/clear), instantiated for step (wrapping) and count (non-wrapping, synchronous load to bit 0).
- Everything else stays in mcycle_sequencer.

Test Plan:
- Reset release, i_IR_Fetch=1 at first boundary with i_Data_Bus=8'h3E → after 4 clocks o_IR=8'h3E, count=0000_0001, step=0001.
- LD-immediate flow: fetch low in M1, high in M2 → count 0000_0001→0000_0010, then back to 0000_0001 with the new opcode latched exactly at 8 clocks.
- i_Wait=1 for 3 clocks at step=0100 → step, count and IR frozen 3 clocks; boundary occurs at clock 7 instead of 4.
- Fetch 8'hCB then fetch 8'hCB → o_CB_Prefix 1 then 0; then fetch 8'h00 → 0.
- i_Halt_Req and i_IR_Fetch both high at boundary → o_Halted=1, o_Exec_En=0, o_IR unchanged; i_Wake raised at step=0010 → RUN only after the next step=1000 clock, count advanced one.
- Never assert fetch for 8 M-cycles → o_Seq_Error=1 at the 8th boundary, o_Exec_En=0, persists until i_Reset_n=0 (async clear mid-cycle verified).
